// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch side and the data
// load/store side. Arbitration is round-robin, with one transaction in flight at
// a time. Every transaction is bounded by a timeout that returns an error.
// All outputs are registered.
module mem_port_arbiter #(
    parameter  int MEM_DEPTH  = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 15,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_data_valid
);

    localparam int                   CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // last_data: 1 when the data side received the most recent grant.
    // owner_data: 1 when the transaction in flight belongs to the data side.
    logic                  last_data;
    logic                  last_data_next;
    logic                  owner_data;
    logic                  owner_data_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;

    logic                  if_gnt_next;
    logic                  if_rvalid_next;
    logic [DATA_WIDTH-1:0] if_rdata_next;
    logic                  if_err_next;
    logic                  d_gnt_next;
    logic                  d_rvalid_next;
    logic [DATA_WIDTH-1:0] d_rdata_next;
    logic                  d_err_next;
    logic [ADDR_WIDTH-1:0] mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_wdata_next;
    logic                  mem_we_next;
    logic                  mem_req_valid_next;

    logic pick_data;
    logic start;
    logic mem_done;
    logic timed_out;

    // On a tie the side that was not granted last wins.
    assign pick_data = d_req & (~if_req | ~last_data);
    assign start     = (state == IDLE) & (if_req | d_req);
    assign mem_done  = (state == BUSY) & mem_data_valid;
    // A response on the final allowed edge counts as a normal completion.
    assign timed_out = (state == BUSY) & ~mem_data_valid & (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (mem_done || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        mem_addr_next      = mem_addr;
        mem_wdata_next     = mem_wdata;
        mem_we_next        = mem_we;
        mem_req_valid_next = mem_req_valid;
        if_gnt_next        = 1'b0;
        d_gnt_next         = 1'b0;
        if_rvalid_next     = 1'b0;
        d_rvalid_next      = 1'b0;
        if_err_next        = 1'b0;
        d_err_next         = 1'b0;
        if_rdata_next      = if_rdata;
        d_rdata_next       = d_rdata;
        owner_data_next    = owner_data;
        last_data_next     = last_data;
        cnt_next           = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    mem_addr_next      = pick_data ? d_addr : if_addr;
                    mem_wdata_next     = pick_data ? d_wdata : '0;
                    mem_we_next        = pick_data & d_we;
                    mem_req_valid_next = 1'b1;
                    if_gnt_next        = ~pick_data;
                    d_gnt_next         = pick_data;
                    owner_data_next    = pick_data;
                    last_data_next     = pick_data;
                    cnt_next           = '0;
                end
            end
            BUSY: begin
                if (mem_done || timed_out) begin
                    mem_req_valid_next = 1'b0;
                    mem_we_next        = 1'b0;
                    if (owner_data) begin
                        d_rvalid_next = 1'b1;
                        d_err_next    = timed_out;
                        d_rdata_next  = (timed_out || mem_we) ? '0 : mem_rdata;
                    end else begin
                        if_rvalid_next = 1'b1;
                        if_err_next    = timed_out;
                        if_rdata_next  = timed_out ? '0 : mem_rdata;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_req_valid <= 1'b0;
            if_gnt        <= 1'b0;
            d_gnt         <= 1'b0;
            if_rvalid     <= 1'b0;
            d_rvalid      <= 1'b0;
            if_err        <= 1'b0;
            d_err         <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            owner_data    <= 1'b0;
            last_data     <= 1'b1;
            cnt           <= '0;
        end else begin
            mem_addr      <= mem_addr_next;
            mem_wdata     <= mem_wdata_next;
            mem_we        <= mem_we_next;
            mem_req_valid <= mem_req_valid_next;
            if_gnt        <= if_gnt_next;
            d_gnt         <= d_gnt_next;
            if_rvalid     <= if_rvalid_next;
            d_rvalid      <= d_rvalid_next;
            if_err        <= if_err_next;
            d_err         <= d_err_next;
            if_rdata      <= if_rdata_next;
            d_rdata       <= d_rdata_next;
            owner_data    <= owner_data_next;
            last_data     <= last_data_next;
            cnt           <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus for mem_port_arbiter, with a
// transaction-level reference model compared against every output on every cycle.
module tb_mem_port_arbiter;

    localparam int MEM_DEPTH = 8;
    localparam int DW        = 32;
    localparam int TIMEOUT   = 15;
    localparam int AW        = $clog2(MEM_DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_req_valid;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_data_valid = 1'b0;

    mem_port_arbiter #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .if_err        (if_err),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .d_err         (d_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_req_valid (mem_req_valid),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    // Memory responder controls: resp_delay = BUSY cycles before data_valid (-1 = never)
    int            resp_delay = 0;
    bit            dv_idle    = 1'b0;
    logic [DW-1:0] rd_val     = '0;

    // Model state and expected outputs
    int            m_phase;     // 0 waiting for a request, 1 transaction open, 2 turnaround
    int            m_age;       // memory-port cycles spent on the open transaction
    bit            m_last_data;
    bit            m_owner;     // 1 = data side owns the open transaction
    bit            m_take_data;
    bit            m_err;
    logic [DW-1:0] m_data;
    logic          e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err;
    logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
    logic [AW-1:0] e_mem_addr;
    logic          e_mem_we, e_mem_req_valid;

    bit model_gnt_q[$];
    bit model_rsp_q[$];
    bit dut_gnt_q[$];
    bit dut_rsp_q[$];
    int rv_count = 0;
    int mrv_cur  = 0;
    int mrv_last = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // which: 0 if_gnt, 1 if_rvalid, 2 d_gnt, 3 d_rvalid
    task automatic wait_evt(input int which, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #2;
            case (which)
                0:       seen = (if_gnt === 1'b1);
                1:       seen = (if_rvalid === 1'b1);
                2:       seen = (d_gnt === 1'b1);
                default: seen = (d_rvalid === 1'b1);
            endcase
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_event_%0d actual=not_seen required=seen_within_%0d_cycles", which, budget);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: raises data_valid once the request has been up resp_delay cycles
    initial begin
        int busy_n;
        busy_n = 0;
        forever begin
            @(negedge clk);
            mem_rdata = rd_val;
            if (mem_req_valid === 1'b1) begin
                mem_data_valid = (busy_n == resp_delay);
                busy_n++;
            end else begin
                busy_n = 0;
                mem_data_valid = dv_idle;
            end
        end
    end

    // Reference model: one transaction at a time, round robin, bounded by TIMEOUT port cycles
    always @(posedge clk) begin
        e_if_gnt   = 1'b0;
        e_d_gnt    = 1'b0;
        e_if_rvalid = 1'b0;
        e_d_rvalid = 1'b0;
        e_if_err   = 1'b0;
        e_d_err    = 1'b0;
        if (reset) begin
            m_phase = 0; m_age = 0; m_last_data = 1'b1; m_owner = 1'b0;
            e_if_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
            e_mem_we = 1'b0; e_mem_req_valid = 1'b0;
        end else if (m_phase == 0) begin
            if (if_req || d_req) begin
                m_take_data     = if_req ? (d_req && !m_last_data) : 1'b1;
                m_owner         = m_take_data;
                m_last_data     = m_take_data;
                e_mem_addr      = m_take_data ? d_addr : if_addr;
                e_mem_we        = m_take_data ? d_we : 1'b0;
                e_mem_wdata     = m_take_data ? d_wdata : '0;
                e_mem_req_valid = 1'b1;
                if (m_take_data) e_d_gnt = 1'b1; else e_if_gnt = 1'b1;
                model_gnt_q.push_back(m_take_data);
                m_age   = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (mem_data_valid || m_age == TIMEOUT) begin
                m_err  = !mem_data_valid;
                m_data = (m_err || (m_owner && e_mem_we)) ? '0 : mem_rdata;
                if (m_owner) begin
                    e_d_rvalid = 1'b1; e_d_err = m_err; e_d_rdata = m_data;
                end else begin
                    e_if_rvalid = 1'b1; e_if_err = m_err; e_if_rdata = m_data;
                end
                e_mem_req_valid = 1'b0;
                e_mem_we        = 1'b0;
                model_rsp_q.push_back(m_owner);
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    end

    // Per-cycle comparison against the model, plus activity logs
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("if_gnt", if_gnt, e_if_gnt);
            chk("if_rvalid", if_rvalid, e_if_rvalid);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("if_err", if_err, e_if_err);
            chk("d_gnt", d_gnt, e_d_gnt);
            chk("d_rvalid", d_rvalid, e_d_rvalid);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("d_err", d_err, e_d_err);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_req_valid", mem_req_valid, e_mem_req_valid);
            if (if_gnt === 1'b1) dut_gnt_q.push_back(1'b0);
            if (d_gnt === 1'b1) dut_gnt_q.push_back(1'b1);
            if (if_rvalid === 1'b1) begin rv_count++; dut_rsp_q.push_back(1'b0); end
            if (d_rvalid === 1'b1) begin rv_count++; dut_rsp_q.push_back(1'b1); end
            if (mem_req_valid === 1'b1) mrv_cur++;
            else if (mrv_cur != 0) begin mrv_last = mrv_cur; mrv_cur = 0; end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int g, r, n0, gq0;

        // Reset state
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_outputs", {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                            mem_addr, mem_wdata, mem_we, mem_req_valid}, '0);

        // Fetch read, data_valid in the third BUSY cycle
        @(negedge clk);
        reset = 1'b0; rd_val = 32'hDEADBEEF; resp_delay = 2;
        @(negedge clk);
        if_req = 1'b1; if_addr = 3'd3;
        wait_evt(0, 10, ok); g = cyc;
        chk("t1_mem_addr", mem_addr, 3);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_req_valid", mem_req_valid, 1);
        @(negedge clk);
        if_req = 1'b0;
        wait_evt(1, 30, ok); r = cyc;
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_if_err", if_err, 0);
        chk("t1_latency", r - g, 3);

        // Data write
        @(negedge clk);
        rd_val = 32'hCAFEF00D; resp_delay = 1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 3'd5; d_wdata = 32'h12345678;
        wait_evt(2, 10, ok);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 32'h12345678);
        chk("t2_mem_addr", mem_addr, 5);
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        wait_evt(3, 30, ok);
        chk("t2_d_rdata", d_rdata, 0);
        chk("t2_d_err", d_err, 0);
        chk("t2_if_rdata_kept", if_rdata, 32'hDEADBEEF);
        chk("t2_if_rvalid_quiet", if_rvalid, 0);

        // Both requesting after reset: grants alternate fetch, data, fetch, data
        @(negedge clk);
        reset = 1'b1; resp_delay = 0;
        @(negedge clk);
        reset = 1'b0;
        model_gnt_q.delete(); model_rsp_q.delete(); dut_gnt_q.delete(); dut_rsp_q.delete();
        rd_val = 32'h000000A5; if_addr = 3'd2; d_addr = 3'd1; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 40 && dut_gnt_q.size() < 4; i++) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 20 && dut_rsp_q.size() < 4; i++) begin
            @(posedge clk);
            #2;
        end
        chk("t3_grant_count", dut_gnt_q.size(), 4);
        chk("t3_resp_count", dut_rsp_q.size(), 4);
        chk("t3_gnt0", dut_gnt_q[0], 0);
        chk("t3_gnt1", dut_gnt_q[1], 1);
        chk("t3_gnt2", dut_gnt_q[2], 0);
        chk("t3_gnt3", dut_gnt_q[3], 1);
        chk("t3_rsp0", dut_rsp_q[0], 0);
        chk("t3_rsp1", dut_rsp_q[1], 1);
        chk("t3_rsp2", dut_rsp_q[2], 0);
        chk("t3_rsp3", dut_rsp_q[3], 1);
        chk("t3_model_gnt1", model_gnt_q[1], 1);
        chk("t3_model_gnt2", model_gnt_q[2], 0);

        // Timeout: memory never answers
        @(negedge clk);
        resp_delay = -1; if_req = 1'b1; if_addr = 3'd6;
        wait_evt(0, 10, ok); g = cyc;
        @(negedge clk);
        if_req = 1'b0;
        wait_evt(1, 40, ok); r = cyc;
        chk("t4_if_err", if_err, 1);
        chk("t4_if_rdata", if_rdata, 0);
        chk("t4_req_valid_cycles", mrv_last, 15);
        chk("t4_latency", r - g, 15);
        @(negedge clk);
        resp_delay = 1; rd_val = 32'h0BADF00D;
        d_req = 1'b1; d_we = 1'b0; d_addr = 3'd4;
        wait_evt(2, 10, ok);
        @(negedge clk);
        d_req = 1'b0;
        wait_evt(3, 30, ok);
        chk("t4_next_d_err", d_err, 0);
        chk("t4_next_d_rdata", d_rdata, 32'h0BADF00D);

        // Boundary: data_valid on the last allowed BUSY edge completes normally
        @(negedge clk);
        resp_delay = 14; rd_val = 32'h55AA55AA; if_req = 1'b1; if_addr = 3'd7;
        wait_evt(0, 10, ok); g = cyc;
        @(negedge clk);
        if_req = 1'b0;
        wait_evt(1, 40, ok); r = cyc;
        chk("t5_if_err", if_err, 0);
        chk("t5_if_rdata", if_rdata, 32'h55AA55AA);
        chk("t5_latency", r - g, 15);
        chk("t5_req_valid_cycles", mrv_last, 15);

        // data_valid while idle produces nothing
        n0 = rv_count;
        @(negedge clk);
        dv_idle = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        @(negedge clk);
        dv_idle = 1'b0;
        chk("t5_idle_dv_rvalids", rv_count - n0, 0);

        // Reset during BUSY abandons the transaction; next tie goes to fetch
        @(negedge clk);
        resp_delay = -1; if_req = 1'b1; if_addr = 3'd2;
        wait_evt(0, 10, ok);
        n0 = rv_count;
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0;
        @(posedge clk);
        #2;
        chk("t6_rst_outputs", {if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                               mem_addr, mem_wdata, mem_we, mem_req_valid}, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_no_rvalid", rv_count - n0, 0);
        @(negedge clk);
        resp_delay = 0; gq0 = dut_gnt_q.size();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 10 && dut_gnt_q.size() <= gq0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("t6_first_tie_fetch", dut_gnt_q[gq0], 0);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        wait_evt(1, 20, ok);

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
